sdram_arbiter: RTL

Round-robin arbiter that shares one `sdram` controller between up to four requesters (CPU, DMA, video fetch, OSD). It converts a per-port level request / single-cycle acknowledge handshake into the controller's edge-triggered `rd`/`we` strobes, then tracks its `ready` low→high sequence. It sits between the core's masters and the `sdram` instance, in the same clock domain.

---
 rtl/sdram_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin arbiter sharing one sdram controller between PORTS requesters,
// turning level req/pulse ack into rd/we strobes and tracking the controller ready handshake.
module sdram_arbiter #(
  parameter int PORTS   = 3,
  parameter int PRIO0   = 0,
  parameter int TIMEOUT = 4095
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [PORTS-1:0]      req_i,
  input  logic [PORTS-1:0]      wr_i,
  input  logic [PORTS*27-1:0]   addr_i,
  input  logic [PORTS*16-1:0]   din_i,
  input  logic [PORTS*2-1:0]    wtbt_i,
  output logic [PORTS-1:0]      ack_o,
  output logic [15:0]           dout_o,
  output logic [PORTS-1:0]      grant_o,
  output logic                  err_o,
  output logic [26:0]           mem_addr_o,
  output logic [15:0]           mem_din_o,
  output logic [1:0]            mem_wtbt_o,
  output logic                  mem_rd_o,
  output logic                  mem_we_o,
  input  logic [15:0]           mem_dout_i,
  input  logic                  mem_ready_i
);
  localparam int PW = $clog2(PORTS);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH, ACK} state_e;
  state_e           state_q;
  logic [PW-1:0]    ptr_q, sel_d, idx_d;
  logic             hit_d, wr_q, err_q, mem_rd_q, mem_we_q;
  logic [CW-1:0]    cnt_q;
  logic [PORTS-1:0] ack_q, grant_q;
  logic [15:0]      dout_q, mem_din_q;
  logic [26:0]      mem_addr_q;
  logic [1:0]       mem_wtbt_q;
  // Scan upward from the port after the last grant; port 0 overrides when prioritised.
  always_comb begin
    sel_d = '0;
    idx_d = '0;
    hit_d = 1'b0;
    for (int k = 1; k <= PORTS; k++) begin
      idx_d = PW'((int'(ptr_q) + k) % PORTS);
      if (!hit_d && req_i[idx_d]) begin
        sel_d = idx_d;
        hit_d = 1'b1;
      end
    end
    if (PRIO0 != 0 && req_i[0]) sel_d = '0;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      ptr_q      <= PW'(PORTS - 1);
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      ack_q      <= '0;
      grant_q    <= '0;
      dout_q     <= '0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_wtbt_q <= '0;
      mem_rd_q   <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (mem_ready_i && |req_i) begin
          mem_addr_q <= addr_i[27*int'(sel_d) +: 27];
          mem_din_q  <= din_i[16*int'(sel_d) +: 16];
          mem_wtbt_q <= wtbt_i[2*int'(sel_d) +: 2];
          mem_rd_q   <= ~wr_i[sel_d];
          mem_we_q   <= wr_i[sel_d];
          wr_q       <= wr_i[sel_d];
          grant_q    <= PORTS'(1) << sel_d;
          ptr_q      <= sel_d;
          cnt_q      <= '0;
          state_q    <= WAIT_LOW;
        end
        WAIT_LOW, WAIT_HIGH: begin
          cnt_q <= cnt_q + 1'b1;
          if (state_q == WAIT_LOW && !mem_ready_i) begin
            mem_rd_q <= 1'b0;
            mem_we_q <= 1'b0;
            state_q  <= WAIT_HIGH;
          end else if (state_q == WAIT_HIGH && mem_ready_i) begin
            if (!wr_q) dout_q <= mem_dout_i;
            ack_q   <= grant_q;
            state_q <= ACK;
          end else if (cnt_q >= CW'(TIMEOUT - 1)) begin
            mem_rd_q <= 1'b0;
            mem_we_q <= 1'b0;
            err_q    <= 1'b1;
            ack_q    <= grant_q;
            state_q  <= ACK;
          end
        end
        default: begin
          ack_q   <= '0;
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign ack_o      = ack_q;
  assign dout_o     = dout_q;
  assign grant_o    = grant_q;
  assign err_o      = err_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_din_o  = mem_din_q;
  assign mem_wtbt_o = mem_wtbt_q;
  assign mem_rd_o   = mem_rd_q;
  assign mem_we_o   = mem_we_q;
endmodule
